// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data memory.
// Data wins ties; a starvation counter forces an instruction grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_ramREN;
  logic              r_ramWEN;
  logic [WORD_W-1:0] r_ramaddr;
  logic [WORD_W-1:0] r_ramstore;
  logic [WORD_W-1:0] r_iload;
  logic [WORD_W-1:0] r_dload;

  logic w_dreq;
  logic w_igrant;

  assign w_dreq   = dREN | dWEN;
  // Instruction wins either when starved or when no data request competes.
  assign w_igrant = iREN & ((r_starve_cnt == MAX_CNT) | ~w_dreq);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_ramREN     <= 1'b0;
      r_ramWEN     <= 1'b0;
      r_ramaddr    <= '0;
      r_ramstore   <= '0;
      r_iload      <= '0;
      r_dload      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_igrant) begin
            r_state      <= ISERV;
            r_ramREN     <= 1'b1;
            r_ramWEN     <= 1'b0;
            r_ramaddr    <= iaddr;
            r_starve_cnt <= '0;
          end else if (w_dreq) begin
            r_state    <= DSERV;
            r_ramREN   <= dREN & ~dWEN;
            r_ramWEN   <= dWEN;
            r_ramaddr  <= daddr;
            r_ramstore <= dstore;
            if (!iREN)
              r_starve_cnt <= '0;
            else if (r_starve_cnt != MAX_CNT)
              r_starve_cnt <= r_starve_cnt + CNT_W'(1);
          end
        end
        DSERV: begin
          if (ram_ready) begin
            r_state  <= IDLE;
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            r_dload  <= ramload;
          end
        end
        ISERV: begin
          if (ram_ready) begin
            r_state  <= IDLE;
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            r_iload  <= ramload;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Hits and load data pass straight through in the ready cycle; the
  // registered copies keep the last value visible afterwards.
  assign dhit     = (r_state == DSERV) & ram_ready;
  assign ihit     = (r_state == ISERV) & ram_ready;
  assign dload    = dhit ? ramload : r_dload;
  assign iload    = ihit ? ramload : r_iload;
  assign ramREN   = r_ramREN;
  assign ramWEN   = r_ramWEN;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data-memory requester.
- The data requester is the mem stage, fed by exec_mem_if.
- Its ihit and dhit outputs feed the pipeline enable/flush logic that drives each stage's en and zero inputs.
- Data requests win ties; a starvation counter guarantees instruction fetch forward progress.

Parameters:
- WORD_W, 32: address and data width.
- STARVE_MAX, 4: consecutive data grants, each made while an instruction request is pending, after which the instruction request is granted first.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- iREN  input  1  instruction read request, held until ihit
- iaddr  input  WORD_W  instruction address
- ihit  output  1  instruction transaction complete, 1-cycle pulse
- iload  output  WORD_W  instruction data, valid when ihit=1
- dREN  input  1  data read request, held until dhit
- dWEN  input  1  data write request, held until dhit
- daddr  input  WORD_W  data address
- dstore  input  WORD_W  write data
- dhit  output  1  data transaction complete, 1-cycle pulse
- dload  output  WORD_W  read data, valid when dhit=1
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  WORD_W  RAM address
- ramstore  output  WORD_W  RAM write data
- ramload  input  WORD_W  RAM read data
- ram_ready  input  1  RAM completes the current access this cycle

Behaviour:
- States: IDLE, DSERV, ISERV.
- Reset (async, any state, including mid-transaction):
  - state=IDLE, starve_cnt=0.
  - ramREN, ramWEN, ramaddr and ramstore all 0.
  - ihit, dhit, iload and dload all 0.
  - The in-flight access is abandoned; no hit is issued.
- IDLE, decision order:
  - (a) iREN and starve_cnt==STARVE_MAX: go to ISERV.
  - (b) else if dREN or dWEN: go to DSERV.
  - (c) else if iREN: go to ISERV.
  - (d) else stay in IDLE.
- Grant capture: on the grant edge, register ramaddr and ramstore, and set ramREN/ramWEN for the granted requester.
  - Instruction grant: ramREN=1, ramWEN=0.
  - Data grant: ramWEN=dWEN, ramREN=dREN&~dWEN. A simultaneous dREN and dWEN is treated as a write.
- Starvation counter, updated on each grant edge:
  - Data grant with iREN=1: starve_cnt increments, saturating at STARVE_MAX.
  - Data grant with iREN=0: starve_cnt resets to 0.
  - Any instruction grant: starve_cnt resets to 0.
- DSERV / ISERV:
  - RAM outputs are held constant until ram_ready=1.
  - Input changes during service are ignored, because the request was captured at grant.
  - In the cycle ram_ready=1, hits and load data are combinational outputs:
    - DSERV: dhit=1, dload=ramload.
    - ISERV: ihit=1, iload=ramload.
  - On the next edge: state returns to IDLE and ramREN/ramWEN clear to 0.
  - iload/dload hold the last value; they are meaningful only with the hit.
- Latency:
  - Request seen in IDLE in cycle 0; the grant edge ends cycle 0.
  - RAM strobe is asserted from cycle 1.
  - The hit occurs in the first cycle >=1 with ram_ready=1. Minimum is 1 cycle after the request.
  - Back-to-back transactions always have one IDLE cycle between them.
- A request withdrawn mid-service still completes at the RAM, and its hit still pulses. The requester ignores the pulse.
- ihit and dhit are never asserted in the same cycle. Neither hit is asserted in IDLE.
- ram_ready=1 in IDLE is ignored.

Test Plan:
- Data read 0x0000_0040, ram_ready on the 3rd serve cycle, ramload=0xDEADBEEF -> ramREN=1 for cycles 1-3; dhit=1 and dload=0xDEADBEEF in cycle 3 only; IDLE in cycle 4.
- Simultaneous iREN and dREN from reset, ram_ready tied 1 -> DSERV first; dhit in cycle 1; IDLE in cycle 2; ISERV granted, ihit in cycle 3.
- iREN held continuously while dWEN is re-asserted every transaction, STARVE_MAX=4 -> four data grants; the 5th grant is an instruction grant; starve_cnt returns to 0.
- Data write with dstore=0x12345678: change daddr and dstore mid-service -> ramaddr and ramstore keep the captured values; ramWEN=1, ramREN=0 until ram_ready.
- dREN=dWEN=1 together -> ramWEN=1, ramREN=0.
- nRST asserted mid-DSERV -> all outputs 0 immediately; no dhit; after release the pending iREN is granted from IDLE.
